occ_fetch_ctrl: RTL and testbench

Sequencer that owns the single-port rom_Occ on behalf of the search pipeline.
- Accepts one parameter set (i, z, k, l, addr, position) per transaction over a valid/ready handshake.
- Issues two rom_Occ reads back to back, Occ(k-1) and Occ(l), and selects the byte lane of the base encoded in position.
- Presents both counts, with the parameters passed through, to the next stage under a second valid/ready handshake.
- Sits between get_param and the interval-update stage.

---
 rtl/occ_fetch_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_occ_fetch_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/occ_fetch_ctrl.sv
// Sequencer that owns the single-port rom_Occ: per accepted parameter set it reads
// Occ(k-1) and Occ(l), picks the byte lane of the base in position, and hands both on.
module occ_fetch_ctrl #(
  parameter int ROM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  position_in,
  input  logic [11:0] addr_in,
  input  logic [7:0]  i_in,
  input  logic [7:0]  z_in,
  input  logic [7:0]  k_in,
  input  logic [7:0]  l_in,
  output logic        ce_rom_Occ,
  output logic [7:0]  addr_rom_Occ,
  input  logic [31:0] data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  position_out,
  output logic [11:0] addr_out,
  output logic [7:0]  i_out,
  output logic [7:0]  z_out,
  output logic [7:0]  k_out,
  output logic [7:0]  l_out,
  output logic [7:0]  occ_k_out,
  output logic [7:0]  occ_l_out,
  output logic        busy,
  output logic [2:0]  state_dbg
);

  // Position codes: per base, INSERTION, DELETION, MATCH, SNP in that order.
  localparam logic [4:0] POS_NONE        = 5'd0;
  localparam logic [4:0] POS_A_INSERTION = 5'd1;
  localparam logic [4:0] POS_A_DELETION  = 5'd2;
  localparam logic [4:0] POS_A_MATCH     = 5'd3;
  localparam logic [4:0] POS_A_SNP       = 5'd4;
  localparam logic [4:0] POS_C_INSERTION = 5'd5;
  localparam logic [4:0] POS_C_DELETION  = 5'd6;
  localparam logic [4:0] POS_C_MATCH     = 5'd7;
  localparam logic [4:0] POS_C_SNP       = 5'd8;
  localparam logic [4:0] POS_G_INSERTION = 5'd9;
  localparam logic [4:0] POS_G_DELETION  = 5'd10;
  localparam logic [4:0] POS_G_MATCH     = 5'd11;
  localparam logic [4:0] POS_G_SNP       = 5'd12;
  localparam logic [4:0] POS_T_INSERTION = 5'd13;
  localparam logic [4:0] POS_T_DELETION  = 5'd14;
  localparam logic [4:0] POS_T_MATCH     = 5'd15;
  localparam logic [4:0] POS_T_SNP       = 5'd16;
  localparam logic [4:0] POS_STOP_1      = 5'd17;
  localparam logic [4:0] POS_STOP_2      = 5'd18;

  localparam logic [1:0] LAT_M1 = 2'(ROM_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE_K = 3'd1,
    S_WAIT_K  = 3'd2,
    S_ISSUE_L = 3'd3,
    S_WAIT_L  = 3'd4,
    S_OUT     = 3'd5
  } state_t;

  state_t      state;
  logic [1:0]  wait_cnt;
  logic [1:0]  lane_q;
  logic [2:0]  lane_in;
  logic [7:0]  lane_byte;

  assign state_dbg = state;

  // Returns {read_needed, lane}; lane 0..3 = A, C, G, T.
  function automatic logic [2:0] lane_of(input logic [4:0] pos);
    logic [2:0] r;
    r = 3'b000;
    case (pos)
      POS_A_INSERTION, POS_A_DELETION, POS_A_MATCH, POS_A_SNP: r = 3'b100;
      POS_C_INSERTION, POS_C_DELETION, POS_C_MATCH, POS_C_SNP: r = 3'b101;
      POS_G_INSERTION, POS_G_DELETION, POS_G_MATCH, POS_G_SNP: r = 3'b110;
      POS_T_INSERTION, POS_T_DELETION, POS_T_MATCH, POS_T_SNP: r = 3'b111;
      POS_NONE, POS_STOP_1, POS_STOP_2:                        r = 3'b000;
      default:                                                 r = 3'b000;
    endcase
    return r;
  endfunction

  assign lane_in = lane_of(position_in);

  always_comb begin
    lane_byte = data[7:0];
    case (lane_q)
      2'd0: lane_byte = data[7:0];
      2'd1: lane_byte = data[15:8];
      2'd2: lane_byte = data[23:16];
      2'd3: lane_byte = data[31:24];
      default: lane_byte = data[7:0];
    endcase
  end

  // Both handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; the sender holds its payload stable while valid is high and ready is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      wait_cnt     <= 2'd0;
      lane_q       <= 2'd0;
      in_ready     <= 1'b1;
      busy         <= 1'b0;
      out_valid    <= 1'b0;
      ce_rom_Occ   <= 1'b0;
      addr_rom_Occ <= 8'd0;
      position_out <= 5'd0;
      addr_out     <= 12'd0;
      i_out        <= 8'd0;
      z_out        <= 8'd0;
      k_out        <= 8'd0;
      l_out        <= 8'd0;
      occ_k_out    <= 8'd0;
      occ_l_out    <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            position_out <= position_in;
            addr_out     <= addr_in;
            i_out        <= i_in;
            z_out        <= z_in;
            k_out        <= k_in;
            l_out        <= l_in;
            lane_q       <= lane_in[1:0];
            occ_k_out    <= 8'd0;
            occ_l_out    <= 8'd0;
            in_ready     <= 1'b0;
            busy         <= 1'b1;
            if (!lane_in[2]) begin
              state     <= S_OUT;
              out_valid <= 1'b1;
            end else if (k_in == 8'd0) begin
              // Occ(-1) is zero by definition, so skip the first read entirely.
              state        <= S_ISSUE_L;
              ce_rom_Occ   <= 1'b1;
              addr_rom_Occ <= l_in;
            end else begin
              state        <= S_ISSUE_K;
              ce_rom_Occ   <= 1'b1;
              addr_rom_Occ <= k_in - 8'd1;
            end
          end
        end
        S_ISSUE_K: begin
          ce_rom_Occ <= 1'b0;
          wait_cnt   <= LAT_M1;
          state      <= S_WAIT_K;
        end
        S_WAIT_K: begin
          if (wait_cnt == 2'd0) begin
            occ_k_out    <= lane_byte;
            state        <= S_ISSUE_L;
            ce_rom_Occ   <= 1'b1;
            addr_rom_Occ <= l_out;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        S_ISSUE_L: begin
          ce_rom_Occ <= 1'b0;
          wait_cnt   <= LAT_M1;
          state      <= S_WAIT_L;
        end
        S_WAIT_L: begin
          if (wait_cnt == 2'd0) begin
            occ_l_out    <= lane_byte;
            state        <= S_OUT;
            out_valid    <= 1'b1;
            addr_rom_Occ <= 8'd0;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        S_OUT: begin
          // in_ready stays low here, so a new set is taken one cycle after release.
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state        <= S_IDLE;
          out_valid    <= 1'b0;
          busy         <= 1'b0;
          in_ready     <= 1'b1;
          ce_rom_Occ   <= 1'b0;
          addr_rom_Occ <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_occ_fetch_ctrl.sv
// Bench for occ_fetch_ctrl: two instances (ROM_LATENCY 1 and 3) with behavioural ROMs,
// directed parameter sets, and a negedge monitor scoring results and ROM reads.
module tb_occ_fetch_ctrl;

  localparam logic [4:0] POS_NONE        = 5'd0;
  localparam logic [4:0] POS_A_INSERTION = 5'd1;
  localparam logic [4:0] POS_A_MATCH     = 5'd3;
  localparam logic [4:0] POS_A_SNP       = 5'd4;
  localparam logic [4:0] POS_C_DELETION  = 5'd6;
  localparam logic [4:0] POS_C_MATCH     = 5'd7;
  localparam logic [4:0] POS_G_SNP       = 5'd12;
  localparam logic [4:0] POS_T_INSERTION = 5'd13;
  localparam logic [4:0] POS_T_MATCH     = 5'd15;
  localparam logic [4:0] POS_STOP_1      = 5'd17;
  localparam logic [4:0] POS_STOP_2      = 5'd18;
  localparam logic [4:0] POS_UNDEF       = 5'd25;
  localparam int RW = 82;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  logic mon_en = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        in_valid     [2];
  logic        in_ready     [2];
  logic [4:0]  position_in  [2];
  logic [11:0] addr_in      [2];
  logic [7:0]  i_in         [2];
  logic [7:0]  z_in         [2];
  logic [7:0]  k_in         [2];
  logic [7:0]  l_in         [2];
  logic        ce_rom_Occ   [2];
  logic [7:0]  addr_rom_Occ [2];
  logic [31:0] data         [2];
  logic        out_valid    [2];
  logic        out_ready    [2];
  logic [4:0]  position_out [2];
  logic [11:0] addr_out     [2];
  logic [7:0]  i_out        [2];
  logic [7:0]  z_out        [2];
  logic [7:0]  k_out        [2];
  logic [7:0]  l_out        [2];
  logic [7:0]  occ_k_out    [2];
  logic [7:0]  occ_l_out    [2];
  logic        busy         [2];
  logic [2:0]  state_dbg    [2];

  logic [31:0] rom_mem [256];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [31:0] pd [3];
    logic        pv [3];

    occ_fetch_ctrl #(.ROM_LATENCY(LAT)) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]),
      .position_in(position_in[g]), .addr_in(addr_in[g]),
      .i_in(i_in[g]), .z_in(z_in[g]), .k_in(k_in[g]), .l_in(l_in[g]),
      .ce_rom_Occ(ce_rom_Occ[g]), .addr_rom_Occ(addr_rom_Occ[g]), .data(data[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]),
      .position_out(position_out[g]), .addr_out(addr_out[g]),
      .i_out(i_out[g]), .z_out(z_out[g]), .k_out(k_out[g]), .l_out(l_out[g]),
      .occ_k_out(occ_k_out[g]), .occ_l_out(occ_l_out[g]),
      .busy(busy[g]), .state_dbg(state_dbg[g])
    );

    // ROM: data valid LAT cycles after the ce cycle, garbage otherwise.
    always @(posedge clk) begin
      if (rst) begin
        pv[0] <= 1'b0; pv[1] <= 1'b0; pv[2] <= 1'b0;
      end else begin
        pv[0] <= ce_rom_Occ[g]; pd[0] <= rom_mem[addr_rom_Occ[g]];
        pv[1] <= pv[0];         pd[1] <= pd[0];
        pv[2] <= pv[1];         pd[2] <= pd[1];
      end
    end
    assign data[g] = pv[LAT-1] ? pd[LAT-1] : 32'hDEAD_BEEF;
  end

  // ---------------- scoreboard ----------------
  logic [RW-1:0] exp_q [$];
  logic [24:0]   ce_q  [$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event not expected or not seen (cycle %0d)", nm, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // ---------------- driver ----------------
  task automatic send(input int d, input logic [4:0] pos, input logic [11:0] a,
                      input logic [7:0] vi, input logic [7:0] vz, input logic [7:0] vk,
                      input logic [7:0] vl, input logic [7:0] eok, input logic [7:0] eol,
                      input int lat, input int nrd);
    int n;
    int guard;
    int lat_rom;
    logic [7:0] km1;
    lat_rom = (d == 0) ? 1 : 3;
    km1 = vk - 8'd1;
    position_in[d] = pos; addr_in[d] = a;
    i_in[d] = vi; z_in[d] = vz; k_in[d] = vk; l_in[d] = vl;
    in_valid[d] = 1'b1;
    guard = 0;
    while (!in_ready[d] && guard < 100) begin
      step();
      guard++;
    end
    if (!in_ready[d]) begin
      fail("accept_timeout");
      in_valid[d] = 1'b0;
      return;
    end
    n = cyc;
    exp_q.push_back({d[0], 16'(n + lat), pos, a, vi, vz, vk, vl, eok, eol});
    if (nrd == 2) begin
      ce_q.push_back({d[0], 16'(n + 1), km1});
      ce_q.push_back({d[0], 16'(n + lat_rom + 2), vl});
    end else if (nrd == 1) begin
      ce_q.push_back({d[0], 16'(n + 1), vl});
    end
    step();
    in_valid[d] = 1'b0;
    position_in[d] = 5'($urandom); addr_in[d] = 12'($urandom);
    i_in[d] = 8'($urandom); z_in[d] = 8'($urandom);
    k_in[d] = 8'($urandom); l_in[d] = 8'($urandom);
  endtask

  // ---------------- monitor ----------------
  int   vstart  [2] = '{0, 0};
  logic pv_q    [2] = '{1'b0, 1'b0};
  logic prev_ce [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        logic [RW-1:0] act;
        logic [RW-1:0] e;
        logic [24:0]   ce_e;
        if (ce_rom_Occ[d]) begin
          if (prev_ce[d]) fail("ce_back_to_back");
          if (ce_q.size() == 0) fail("ce_unexpected");
          else begin
            ce_e = ce_q.pop_front();
            chk("ce_read", {d[0], cyc[15:0], addr_rom_Occ[d]}, ce_e);
          end
        end
        if (out_valid[d] && !pv_q[d]) vstart[d] = cyc;
        if (!busy[d])
          chk("idle_outputs", {in_ready[d], out_valid[d], ce_rom_Occ[d], addr_rom_Occ[d]},
              {1'b1, 1'b0, 1'b0, 8'h00});
        else if (out_valid[d])
          chk("out_state_outputs", {in_ready[d], ce_rom_Occ[d], addr_rom_Occ[d]}, 10'h000);
        if (out_valid[d]) begin
          act = {d[0], vstart[d][15:0], position_out[d], addr_out[d], i_out[d], z_out[d],
                 k_out[d], l_out[d], occ_k_out[d], occ_l_out[d]};
          if (exp_q.size() == 0) fail("out_valid_unexpected");
          else if (out_ready[d]) begin
            e = exp_q.pop_front();
            chk("result", act, e);
          end else begin
            chk("held_result", act[64:0], exp_q[0][64:0]);
          end
        end
        prev_ce[d] = ce_rom_Occ[d];
        pv_q[d]    = out_valid[d];
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; out_ready[d] = 1'b1;
      position_in[d] = '0; addr_in[d] = '0;
      i_in[d] = '0; z_in[d] = '0; k_in[d] = '0; l_in[d] = '0;
    end
    for (int a = 0; a < 256; a++) rom_mem[a] = $urandom;
    rom_mem[8'h00] = 32'h0102_0304;
    rom_mem[8'h02] = 32'h0A0B_0C0D;
    rom_mem[8'h05] = 32'hAB00_0000;
    rom_mem[8'h08] = 32'h5AA5_0F0F;
    rom_mem[8'h0F] = 32'h4433_2211;
    rom_mem[8'h20] = 32'h8877_6655;
    rom_mem[8'h2F] = 32'h11CD_2233;
    rom_mem[8'h7F] = 32'h0000_003C;
    rom_mem[8'hFF] = 32'hFFFF_FF99;

    step();
    step();
    for (int d = 0; d < 2; d++) begin
      chk("reset_ctl", {in_ready[d], busy[d], out_valid[d], ce_rom_Occ[d], state_dbg[d]},
          {1'b1, 1'b0, 1'b0, 1'b0, 3'd0});
      chk("reset_addr_rom", addr_rom_Occ[d], 8'h00);
      chk("reset_fields", {position_out[d], addr_out[d], i_out[d], z_out[d], k_out[d], l_out[d]}, 0);
      chk("reset_occ", {occ_k_out[d], occ_l_out[d]}, 16'h0000);
    end
    rst = 1'b0;
    mon_en = 1'b1;
    step();

    // Latency 1 instance: full path, k=0, no-read codes, k>l, l=255.
    send(0, POS_C_DELETION, 12'h123, 8'h11, 8'h22, 8'h10, 8'h20, 8'h22, 8'h66, 5, 2);
    send(0, POS_T_MATCH,    12'h456, 8'h33, 8'h44, 8'h00, 8'h05, 8'h00, 8'hAB, 3, 1);
    send(0, POS_STOP_1,     12'hABC, 8'h55, 8'h66, 8'h03, 8'h09, 8'h00, 8'h00, 1, 0);
    send(0, POS_G_SNP,      12'h0F0, 8'h77, 8'h88, 8'h30, 8'h08, 8'hCD, 8'hA5, 5, 2);
    send(0, POS_A_SNP,      12'hFFF, 8'hFF, 8'h00, 8'h80, 8'hFF, 8'h3C, 8'h99, 5, 2);
    send(0, POS_UNDEF,      12'h001, 8'h01, 8'h02, 8'h10, 8'h20, 8'h00, 8'h00, 1, 0);
    send(0, POS_NONE,       12'h002, 8'h03, 8'h04, 8'h01, 8'h02, 8'h00, 8'h00, 1, 0);
    send(0, POS_STOP_2,     12'h003, 8'h05, 8'h06, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0);

    // Backpressure: hold the result for 4 OUT cycles while a second set waits.
    guard = 0;
    while ((exp_q.size() != 0) && guard < 50) begin step(); guard++; end
    out_ready[0] = 1'b0;
    send(0, POS_C_MATCH, 12'h5A5, 8'hC1, 8'hC2, 8'h01, 8'h02, 8'h03, 8'h0C, 5, 2);
    guard = 0;
    while (!out_valid[0] && guard < 50) begin step(); guard++; end
    if (!out_valid[0]) fail("out_valid_timeout");
    fork
      send(0, POS_A_MATCH, 12'hA5A, 8'hD1, 8'hD2, 8'h00, 8'h20, 8'h00, 8'h55, 3, 1);
      begin
        repeat (4) step();
        out_ready[0] = 1'b1;
      end
    join

    // Reset while waiting for the Occ(k-1) data: the set is dropped.
    guard = 0;
    while ((exp_q.size() != 0 || busy[0]) && guard < 50) begin step(); guard++; end
    position_in[0] = POS_C_DELETION; addr_in[0] = 12'h777;
    i_in[0] = 8'h01; z_in[0] = 8'h02; k_in[0] = 8'h10; l_in[0] = 8'h20;
    in_valid[0] = 1'b1;
    ce_q.push_back({1'b0, 16'(cyc + 1), 8'h0F});
    step();
    in_valid[0] = 1'b0;
    step();
    chk("abort_in_wait_k", state_dbg[0], 3'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_to_idle", {state_dbg[0], busy[0], out_valid[0], ce_rom_Occ[0], in_ready[0]},
        {3'd0, 1'b0, 1'b0, 1'b0, 1'b1});
    repeat (6) step();

    // Latency 3 instance.
    send(1, POS_A_INSERTION, 12'h321, 8'h9A, 8'hBC, 8'h01, 8'h02, 8'h04, 8'h0D, 9, 2);
    send(1, POS_T_INSERTION, 12'h654, 8'h12, 8'h34, 8'h00, 8'h05, 8'h00, 8'hAB, 5, 1);

    guard = 0;
    while ((exp_q.size() != 0 || ce_q.size() != 0) && guard < 200) begin step(); guard++; end
    chk("results_drained", exp_q.size(), 0);
    chk("reads_drained", ce_q.size(), 0);
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
